// File: rtl/service_mode_ctrl.sv
// Service-mode arbiter: hands one of four services the display and push buttons.
// It waits for the service to acknowledge shutdown, or times out and flags an error.

module svc_sync_lane (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic lvl
);
  logic s1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1  <= 1'b0;
      lvl <= 1'b0;
    end else begin
      s1  <= raw;
      lvl <= s1;
    end
  end
endmodule

module service_mode_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  spdt,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  input  logic [3:0]  finish,
  input  logic [15:0] cur_time,
  input  logic [63:0] svc_disp,
  input  logic [15:0] svc_sel,
  output logic [3:0]  srv_en,
  output logic        pu_o,
  output logic        pd_o,
  output logic        pl_o,
  output logic        pr_o,
  output logic [15:0] disp,
  output logic [3:0]  disp_sel,
  output logic        err
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} state_t;

  logic [NUM_LANES-1:0] raw, lvl;
  logic [3:0]           spdt_s, btn_s, btn_prv, btn_rise, btn_pick, pulse_q;
  logic [3:0][15:0]     disp_a;
  logic [3:0][3:0]      sel_a;
  state_t               state, state_nx;
  logic [1:0]           owner, owner_nx, low_idx;
  logic [3:0]           cnt, cnt_nx;
  logic                 err_set;

  assign raw    = {push_r, push_l, push_d, push_u, spdt};
  assign spdt_s = lvl[3:0];
  assign btn_s  = lvl[7:4];
  assign disp_a = svc_disp;
  assign sel_a  = svc_sel;

  svc_sync_lane u_lane [NUM_LANES-1:0] (
    .clk    (clk),
    .resetn (resetn),
    .raw    (raw),
    .lvl    (lvl)
  );

  // Bit 0 (up) has the highest priority, so isolating the lowest set bit picks the winner.
  assign btn_rise = btn_s & ~btn_prv;
  assign btn_pick = btn_rise & (~btn_rise + 4'd1);
  assign {pr_o, pl_o, pd_o, pu_o} = pulse_q;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (spdt_s[i]) low_idx = 2'(i);
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = cnt;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (|spdt_s) begin
          state_nx = ACTIVE;
          owner_nx = low_idx;
        end
      end
      ACTIVE: begin
        if (!spdt_s[owner]) begin
          state_nx = CLOSE;
          cnt_nx   = 4'd0;
        end
      end
      CLOSE: begin
        if (finish[owner]) begin
          state_nx = IDLE;
        end else if (cnt == 4'd15) begin
          state_nx = IDLE;
          err_set  = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    srv_en = 4'd0;
    if (state == ACTIVE) srv_en[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 2'd0;
      cnt      <= 4'd0;
      err      <= 1'b0;
      btn_prv  <= 4'd0;
      pulse_q  <= 4'd0;
      disp     <= 16'd0;
      disp_sel <= 4'd0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
      err     <= err | err_set;
      btn_prv <= btn_s;
      pulse_q <= (state == ACTIVE) ? btn_pick : 4'd0;
      if (state == ACTIVE) begin
        disp     <= disp_a[owner];
        disp_sel <= sel_a[owner];
      end else begin
        disp     <= cur_time;
        disp_sel <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_service_mode_ctrl.sv
// Scoreboard bench for service_mode_ctrl: stimulus queues expected output changes
// with the cycle they must appear in; a negedge monitor pops and compares them.

module tb_service_mode_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  spdt, finish;
  logic        push_u, push_d, push_l, push_r;
  logic [15:0] cur_time;
  logic [63:0] svc_disp;
  logic [15:0] svc_sel;
  logic [3:0]  srv_en;
  logic        pu_o, pd_o, pl_o, pr_o;
  logic [15:0] disp;
  logic [3:0]  disp_sel;
  logic        err;

  service_mode_ctrl dut (
    .clk(clk), .resetn(resetn), .spdt(spdt),
    .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .finish(finish), .cur_time(cur_time), .svc_disp(svc_disp), .svc_sel(svc_sel),
    .srv_en(srv_en), .pu_o(pu_o), .pd_o(pd_o), .pl_o(pl_o), .pr_o(pr_o),
    .disp(disp), .disp_sel(disp_sel), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_SRV = 0, K_DISP = 1, K_SEL = 2, K_PUL = 3, K_ERR = 4, K_SNAP = 5;

  typedef struct packed {
    int          lo;
    int          hi;
    logic [31:0] val;
  } exp_t;

  exp_t q_srv[$], q_disp[$], q_sel[$], q_pul[$], q_err[$], q_snap[$];
  int   n_cmp = 0, n_bad = 0;
  int   snap_req = 0, snap_done = 0;
  bit   mon_en = 1'b0, started = 1'b0;
  logic [3:0]  p_srv, p_sel;
  logic [15:0] p_disp;
  logic        p_err;

  function automatic string kname(input int k);
    case (k)
      K_SRV:   return "srv_en";
      K_DISP:  return "disp";
      K_SEL:   return "disp_sel";
      K_PUL:   return "pulse";
      K_ERR:   return "err";
      default: return "snapshot";
    endcase
  endfunction

  task automatic ex(input int k, input int lo, input int hi, input logic [31:0] v);
    exp_t e;
    e.lo = lo; e.hi = hi; e.val = v;
    case (k)
      K_SRV:   q_srv.push_back(e);
      K_DISP:  q_disp.push_back(e);
      K_SEL:   q_sel.push_back(e);
      K_PUL:   q_pul.push_back(e);
      K_ERR:   q_err.push_back(e);
      default: q_snap.push_back(e);
    endcase
  endtask

  task automatic ex1(input int k, input int c, input logic [31:0] v);
    ex(k, c, c, v);
  endtask

  task automatic observe(input int k, input logic [31:0] v);
    exp_t e;
    bit   got = 1'b0;
    e = '0;
    case (k)
      K_SRV:   if (q_srv.size()  > 0) begin e = q_srv.pop_front();  got = 1'b1; end
      K_DISP:  if (q_disp.size() > 0) begin e = q_disp.pop_front(); got = 1'b1; end
      K_SEL:   if (q_sel.size()  > 0) begin e = q_sel.pop_front();  got = 1'b1; end
      K_PUL:   if (q_pul.size()  > 0) begin e = q_pul.pop_front();  got = 1'b1; end
      K_ERR:   if (q_err.size()  > 0) begin e = q_err.pop_front();  got = 1'b1; end
      default: if (q_snap.size() > 0) begin e = q_snap.pop_front(); got = 1'b1; end
    endcase
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: unexpected value %h at cycle %0d", kname(k), v, cyc);
    end else if (v !== e.val || cyc < e.lo || cyc > e.hi) begin
      n_bad++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d..%0d",
               kname(k), v, cyc, e.val, e.lo, e.hi);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!started) begin
        p_srv = srv_en; p_disp = disp; p_sel = disp_sel; p_err = err;
        started = 1'b1;
      end else begin
        if (srv_en !== p_srv)    begin observe(K_SRV,  {28'h0, srv_en});   p_srv  = srv_en;   end
        if (disp !== p_disp)     begin observe(K_DISP, {16'h0, disp});     p_disp = disp;     end
        if (disp_sel !== p_sel)  begin observe(K_SEL,  {28'h0, disp_sel}); p_sel  = disp_sel; end
        if ({pr_o, pl_o, pd_o, pu_o} !== 4'h0)
          observe(K_PUL, {28'h0, pr_o, pl_o, pd_o, pu_o});
        if (err !== p_err)       begin observe(K_ERR,  {31'h0, err});      p_err  = err;      end
      end
      if (snap_req != snap_done) begin
        observe(K_SNAP, {3'b0, srv_en, pr_o, pl_o, pd_o, pu_o, disp, disp_sel, err});
        snap_done++;
      end
    end
  end

  function automatic logic [31:0] sv(input logic [3:0] s, input logic [3:0] p,
                                     input logic [15:0] d, input logic [3:0] ds, input logic e);
    return {3'b0, s, p, d, ds, e};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic [31:0] v);
    ex1(K_SNAP, cyc, v);
    snap_req++;
  endtask

  // b and exp are {r,l,d,u}; exp = 0 means the press must produce no pulse.
  task automatic press(input logic [3:0] b, input logic [3:0] exp);
    int t;
    t = cyc;
    {push_r, push_l, push_d, push_u} = b;
    if (exp != 4'h0) ex1(K_PUL, t + 3, {28'h0, exp});
    tick(1);
    {push_r, push_l, push_d, push_u} = 4'h0;
    tick(4);
  endtask

  task automatic drain(input int k, inout exp_t q[$]);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expected %h at cycle %0d..%0d never seen", kname(k), e.val, e.lo, e.hi);
    end
  endtask

  initial begin
    int t;
    resetn = 1'b0; spdt = 4'h0; finish = 4'h0;
    {push_r, push_l, push_d, push_u} = 4'h0;
    cur_time = 16'h1259;
    svc_disp = {16'h3434, 16'h2323, 16'h1212, 16'h0101};
    svc_sel  = {4'b0100, 4'b0001, 4'b1000, 4'b0010};

    tick(3);
    snap(sv(4'h0, 4'h0, 16'h0000, 4'h0, 1'b0));
    mon_en = 1'b1;
    resetn = 1'b1;
    ex1(K_DISP, cyc + 1, 32'h1259);
    tick(2);

    // Service 2 takes over; buttons route only to it, with u > d > l > r.
    t = cyc; spdt = 4'b0100;
    ex1(K_SRV, t + 3, 32'b0100); ex1(K_DISP, t + 4, 32'h2323); ex1(K_SEL, t + 4, 32'b0001);
    tick(6);
    press(4'b1000, 4'b1000);
    repeat (3) press(4'b0001, 4'b0001);
    press(4'b0011, 4'b0001);
    press(4'b1100, 4'b0100);

    // Close service 2; wrong-bit finish ignored, then lowest-index pick of 0110 is 1.
    t = cyc; spdt = 4'b0000;
    ex1(K_SRV, t + 3, 32'b0000); ex1(K_DISP, t + 4, 32'h1259); ex1(K_SEL, t + 4, 32'b0000);
    tick(4); spdt = 4'b0110; finish = 4'b0010;
    tick(1); finish = 4'b0000;
    tick(1); finish = 4'b0100;
    ex1(K_SRV, t + 8, 32'b0010); ex1(K_DISP, t + 9, 32'h1212); ex1(K_SEL, t + 9, 32'b1000);
    tick(1); finish = 4'b0000;
    tick(6); spdt = 4'b1110;
    tick(6); spdt = 4'b1010;
    tick(6);

    // Close service 1 with a finish five cycles after the drop; no error, idle buttons dead.
    t = cyc; spdt = 4'b0000;
    ex1(K_SRV, t + 3, 32'b0000); ex1(K_DISP, t + 4, 32'h1259); ex1(K_SEL, t + 4, 32'b0000);
    tick(5); finish = 4'b0010;
    tick(1); finish = 4'b0000;
    tick(3);
    press(4'b0100, 4'b0000);
    press(4'b0011, 4'b0000);
    snap(sv(4'h0, 4'h0, 16'h1259, 4'h0, 1'b0));

    // Timeout path: no finish, err rises after the close counter expires.
    t = cyc; spdt = 4'b0010;
    ex1(K_SRV, t + 3, 32'b0010); ex1(K_DISP, t + 4, 32'h1212); ex1(K_SEL, t + 4, 32'b1000);
    tick(6);
    t = cyc; spdt = 4'b0000;
    ex1(K_SRV, t + 3, 32'b0000); ex1(K_DISP, t + 4, 32'h1259); ex1(K_SEL, t + 4, 32'b0000);
    ex(K_ERR, t + 18, t + 19, 32'h1);
    tick(5); push_d = 1'b1;
    tick(1); push_d = 1'b0;
    tick(16);
    t = cyc; spdt = 4'b0001;
    ex1(K_SRV, t + 3, 32'b0001); ex1(K_DISP, t + 4, 32'h0101); ex1(K_SEL, t + 4, 32'b0010);
    tick(6);

    // Reset mid-session clears everything, including err; spdt[0] still high re-enters.
    t = cyc; resetn = 1'b0;
    ex1(K_SRV, t + 1, 32'h0); ex1(K_DISP, t + 1, 32'h0); ex1(K_SEL, t + 1, 32'h0);
    ex1(K_ERR, t + 1, 32'h0);
    tick(1);
    snap(sv(4'h0, 4'h0, 16'h0000, 4'h0, 1'b0));
    tick(1); resetn = 1'b1;
    ex1(K_DISP, t + 3, 32'h1259);
    ex1(K_SRV, t + 5, 32'b0001); ex1(K_DISP, t + 6, 32'h0101); ex1(K_SEL, t + 6, 32'b0010);
    tick(8);

    drain(K_SRV, q_srv);
    drain(K_DISP, q_disp);
    drain(K_SEL, q_sel);
    drain(K_PUL, q_pul);
    drain(K_ERR, q_err);
    drain(K_SNAP, q_snap);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/service_mode_ctrl.md
SERVICE_MODE_CTRL -- requirements
Module: service_mode_ctrl

Interface
- REQ-001: One clock; reset is synchronous and active-low, ports named clk and resetn.
- REQ-002: clk  in  1  system clock, all state updates on rising edge.
- REQ-003: resetn  in  1  synchronous active-low reset.
- REQ-004: spdt  in  4  raw mode switches; bit k selects service k (k=0..3).
- REQ-005: push_u, push_d, push_l, push_r  in  1 each  raw push buttons.
- REQ-006: finish  in  4  one-cycle done pulse from service k after its enable drops.
- REQ-007: cur_time  in  16  BCD HH:MM clock value shown when no service is active.
- REQ-008: svc_disp  in  64  BCD display value of service k in bits [16k+15:16k].
- REQ-009: svc_sel  in  16  one-hot digit-select of service k in bits [4k+3:4k].
- REQ-010: srv_en  out  4  one-hot service enable; 0 = idle.
- REQ-011: pu_o, pd_o, pl_o, pr_o  out  1 each  one-cycle button pulses routed to the active service.
- REQ-012: disp  out  16  value to the 4-digit display.
- REQ-013: disp_sel  out  4  digit-select to the display (blink position).
- REQ-014: err  out  1  sticky finish-timeout flag.

Function
- REQ-015: All spdt and push inputs SHALL pass through a 2-flop synchronizer before use.
- REQ-016: Button pulse SHALL be (sync2 & ~prev), registered: raw high before edge n gives pulse high from edge n+2 to n+3, exactly one cycle per press.
- REQ-017: If several button pulses qualify in one cycle, only the highest priority SHALL be forwarded (u > d > l > r); the others are dropped.
- REQ-018: Button pulses SHALL be forwarded only in ACTIVE; in IDLE and CLOSE they are dropped.
- REQ-019: FSM states: IDLE, ACTIVE(k), CLOSE(k); state register plus 2-bit owner index k.
- REQ-020: IDLE -> ACTIVE(k) when any synced spdt bit is 1; k = lowest set index; srv_en[k] high from the next edge.
- REQ-021: In ACTIVE(k), changes on spdt bits other than k SHALL be ignored.
- REQ-022: ACTIVE(k) -> CLOSE(k) when synced spdt[k] is 0; srv_en drops to 0 on the same edge.
- REQ-023: CLOSE(k) -> IDLE when finish[k] = 1; finish on other bits SHALL be ignored.
- REQ-024: CLOSE has a 4-bit timeout counter cleared on entry; on reaching 15 without finish[k], go to IDLE and set err.
- REQ-025: From IDLE, a switch still high after CLOSE SHALL re-enter ACTIVE with lowest-index rule, no extra idle cycle required beyond one.
- REQ-026: disp/disp_sel registered: IDLE and CLOSE give cur_time and 4'b0000; ACTIVE(k) gives svc_disp[k] and svc_sel[k], one cycle latency.
- REQ-027: err cleared only by reset.

Reset
- REQ-028: While resetn = 0 at a rising edge: state IDLE, srv_en = 0, all pulse outputs 0, disp = 0, disp_sel = 0, err = 0, synchronizers and counter cleared.
- REQ-029: Reset asserted mid-ACTIVE or mid-CLOSE SHALL abandon the session with no finish wait; the next session starts per REQ-020.

Verification
- REQ-030: spdt = 4'b0100 after reset -> srv_en = 4'b0100 within 3 edges; disp follows svc_disp[47:32].
- REQ-031: In ACTIVE(2), push_r high 1 cycle -> pr_o high exactly 1 cycle, 2 edges later; 3 push_u presses -> 3 pu_o pulses.
- REQ-032: push_u and push_d high in same cycle -> only pu_o pulses; in IDLE any push -> no pulse.
- REQ-033: spdt 4'b0110 from IDLE -> srv_en = 4'b0010; raise spdt[3] while active -> no change.
- REQ-034: Drop spdt[1], finish[1] pulsed 5 cycles later -> srv_en = 0 at drop, IDLE after finish, err = 0; repeat with no finish -> IDLE after 15 cycles, err = 1.
- REQ-035: resetn low during ACTIVE(0) -> all outputs 0 next edge; release with spdt[0] high -> ACTIVE(0) again.
